// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32 control path: FSM states, opcodes, ALU codes
// and datapath mux selects, used by both the multicycle and single-cycle controllers.
package rv32_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_for_op(input logic [6:0] op);
        case (op)
            OP_SW:     imm_for_op = IMM_S;
            OP_BRANCH: imm_for_op = IMM_B;
            OP_JAL:    imm_for_op = IMM_J;
            default:   imm_for_op = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the coarse aluop from the controller plus funct fields to an ALU operation.
module alu_decoder
    import rv32_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // IR[30] only means sub for R-type; for addi it is an immediate bit
                    3'b000:  alucontrol = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle RV32 controller: sequences fetch/decode/execute/memory/writeback
// over a shared memory with a ready handshake, driving all datapath selects.
module mc_ctrl_unit
    import rv32_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [6:0]         op_i,
    input  logic [2:0]         funct3_i,
    input  logic               funct7b5_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               adrsrc_o,
    output logic               irwrite_o,
    output logic               pcwrite_o,
    output logic               regwrite_o,
    output logic [1:0]         alusrca_o,
    output logic [1:0]         alusrcb_o,
    output logic [1:0]         resultsrc_o,
    output logic [1:0]         immsrc_o,
    output logic [2:0]         alucontrol_o,
    output logic               illegal_o,
    output logic [STATE_W-1:0] state_o
);

    state_t     state_reg;
    state_t     state_next;
    logic [1:0] aluop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    state_next = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECR;
                    OP_IALU:      state_next = S_EXECI;
                    OP_BRANCH:    state_next = S_BRANCH;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = mem_ready_i ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = mem_ready_i ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        adrsrc_o    = 1'b0;
        irwrite_o   = 1'b0;
        pcwrite_o   = 1'b0;
        regwrite_o  = 1'b0;
        illegal_o   = 1'b0;
        alusrca_o   = SRCA_PC;
        alusrcb_o   = SRCB_RD2;
        resultsrc_o = RES_ALUOUT;
        aluop       = ALUOP_ADD;
        case (state_reg)
            S_FETCH: begin
                // PC+4 goes straight from the ALU into PC as the word is captured
                mem_req_o   = 1'b1;
                alusrcb_o   = SRCB_FOUR;
                resultsrc_o = RES_ALURESULT;
                irwrite_o   = mem_ready_i;
                pcwrite_o   = mem_ready_i;
            end
            S_DECODE: begin
                alusrca_o = SRCA_OLDPC;
                alusrcb_o = SRCB_IMM;
                case (op_i)
                    OP_LW, OP_SW, OP_RTYPE, OP_IALU, OP_BRANCH, OP_JAL: illegal_o = 1'b0;
                    default: illegal_o = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca_o = SRCA_RD1;
                alusrcb_o = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req_o = 1'b1;
                adrsrc_o  = 1'b1;
            end
            S_MEMWB: begin
                resultsrc_o = RES_DATA;
                regwrite_o  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                adrsrc_o  = 1'b1;
            end
            S_EXECR: begin
                alusrca_o = SRCA_RD1;
                aluop     = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alusrca_o = SRCA_RD1;
                alusrcb_o = SRCB_IMM;
                aluop     = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regwrite_o = 1'b1;
            end
            S_BRANCH: begin
                alusrca_o = SRCA_RD1;
                aluop     = ALUOP_SUB;
                pcwrite_o = zero_i ^ funct3_i[0];
            end
            S_JAL: begin
                alusrca_o = SRCA_OLDPC;
                alusrcb_o = SRCB_FOUR;
                pcwrite_o = 1'b1;
            end
            default: begin
                mem_req_o = 1'b0;
            end
        endcase
        // Reset must suppress every write even though the state register still
        // holds a mid-instruction state until the reset edge.
        if (rst_i) begin
            mem_req_o  = 1'b0;
            mem_we_o   = 1'b0;
            irwrite_o  = 1'b0;
            pcwrite_o  = 1'b0;
            regwrite_o = 1'b0;
            illegal_o  = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3_i),
        .funct7b5   (funct7b5_i),
        .op5        (op_i[5]),
        .alucontrol (alucontrol_o)
    );

    assign immsrc_o = imm_for_op(op_i);
    assign state_o  = STATE_W'(state_reg);

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Scenario bench for mc_ctrl_unit: each task queues per-cycle expected outputs
// with their stimulus, then replays the queue cycle by cycle against the DUT.
module tb_mc_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [6:0] op_i = 7'd0;
    logic [2:0] funct3_i = 3'd0;
    logic       funct7b5_i = 1'b0;
    logic       zero_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       mem_req_o, mem_we_o, adrsrc_o, irwrite_o, pcwrite_o, regwrite_o, illegal_o;
    logic [1:0] alusrca_o, alusrcb_o, resultsrc_o, immsrc_o;
    logic [2:0] alucontrol_o;
    logic [3:0] state_o;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mc_ctrl_unit #(.STATE_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .op_i         (op_i),
        .funct3_i     (funct3_i),
        .funct7b5_i   (funct7b5_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .adrsrc_o     (adrsrc_o),
        .irwrite_o    (irwrite_o),
        .pcwrite_o    (pcwrite_o),
        .regwrite_o   (regwrite_o),
        .alusrca_o    (alusrca_o),
        .alusrcb_o    (alusrcb_o),
        .resultsrc_o  (resultsrc_o),
        .immsrc_o     (immsrc_o),
        .alucontrol_o (alucontrol_o),
        .illegal_o    (illegal_o),
        .state_o      (state_o)
    );

    // state, {req,we,adr,irw,pcw,rgw,ill}, A, B, result, alucontrol
    typedef struct packed {
        logic [3:0] st;
        logic [6:0] strobes;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] rs;
        logic [2:0] alu;
    } out_t;

    typedef struct {
        logic  rdy;
        logic  zero;
        logic  rst;
        out_t  exp;
        string name;
    } txn_t;

    out_t obs;
    assign obs = {state_o, mem_req_o, mem_we_o, adrsrc_o, irwrite_o, pcwrite_o,
                  regwrite_o, illegal_o, alusrca_o, alusrcb_o, resultsrc_o, alucontrol_o};

    txn_t sb[$];

    function automatic out_t ev(input logic [3:0] st, input logic [6:0] s,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] rs, input logic [2:0] alu);
        ev = {st, s, a, b, rs, alu};
    endfunction

    function automatic out_t e_fetch(input logic r);
        e_fetch = ev(4'd0, {1'b1, 1'b0, 1'b0, r, r, 1'b0, 1'b0}, 2'b00, 2'b10, 2'b10, 3'b000);
    endfunction
    function automatic out_t e_decode(input logic ill);
        e_decode = ev(4'd1, {6'b0, ill}, 2'b01, 2'b01, 2'b00, 3'b000);
    endfunction
    function automatic out_t e_memadr();
        e_memadr = ev(4'd2, 7'b0000000, 2'b10, 2'b01, 2'b00, 3'b000);
    endfunction
    function automatic out_t e_memread();
        e_memread = ev(4'd3, 7'b1010000, 2'b00, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic out_t e_memwb();
        e_memwb = ev(4'd4, 7'b0000010, 2'b00, 2'b00, 2'b01, 3'b000);
    endfunction
    function automatic out_t e_memwrite();
        e_memwrite = ev(4'd5, 7'b1110000, 2'b00, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic out_t e_exec(input logic imm, input logic [2:0] alu);
        e_exec = ev(imm ? 4'd7 : 4'd6, 7'b0, 2'b10, imm ? 2'b01 : 2'b00, 2'b00, alu);
    endfunction
    function automatic out_t e_aluwb();
        e_aluwb = ev(4'd8, 7'b0000010, 2'b00, 2'b00, 2'b00, 3'b000);
    endfunction
    function automatic out_t e_branch(input logic p);
        e_branch = ev(4'd9, {4'b0, p, 2'b0}, 2'b10, 2'b00, 2'b00, 3'b001);
    endfunction
    function automatic out_t e_jal();
        e_jal = ev(4'd10, 7'b0000100, 2'b01, 2'b10, 2'b00, 3'b000);
    endfunction

    function automatic txn_t mk(input logic rdy, input logic zero, input logic rst,
                                input out_t exp, input string name);
        mk.rdy = rdy; mk.zero = zero; mk.rst = rst; mk.exp = exp; mk.name = name;
    endfunction

    task automatic set_ir(input logic [31:0] ir);
        op_i       = ir[6:0];
        funct3_i   = ir[14:12];
        funct7b5_i = ir[30];
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        mem_ready_i = 1'b1;
        set_ir(32'h002081B3);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            #4;
            total++;
            if (obs !== ev(4'd0, 7'b0, 2'b00, 2'b10, 2'b10, 3'b000)) begin
                bad++;
                $display("FAIL reset_hold%0d: got %h want %h", i, obs,
                         ev(4'd0, 7'b0, 2'b00, 2'b10, 2'b10, 3'b000));
            end else $display("ok   reset_hold%0d: %h", i, obs);
            @(posedge clk);
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] irs [10] = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3,
                                  32'h0020A1B3, 32'h00108093, 32'h40008093, 32'h0010E093,
                                  32'h0010A093, 32'h0010F093};
        logic [2:0]  alus [10] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101,
                                   3'b000, 3'b000, 3'b011, 3'b101, 3'b010};
        txn_t t;
        for (int k = 0; k < 10; k++) begin
            set_ir(irs[k]);
            sb.push_back(mk(1'b1, 1'b0, 1'b0, e_fetch(1'b1), $sformatf("alu%0d_fetch", k)));
            sb.push_back(mk(1'b1, 1'b0, 1'b0, e_decode(1'b0), $sformatf("alu%0d_decode", k)));
            sb.push_back(mk(1'b1, 1'b0, 1'b0, e_exec(!irs[k][5], alus[k]), $sformatf("alu%0d_exec", k)));
            sb.push_back(mk(1'b1, 1'b0, 1'b0, e_aluwb(), $sformatf("alu%0d_wb", k)));
            while (sb.size() > 0) begin
                t = sb.pop_front();
                #1; mem_ready_i = t.rdy; zero_i = t.zero; rst_i = t.rst;
                #3; total++;
                if (obs !== t.exp) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", t.name, obs, t.exp);
                end else $display("ok   %s: %h", t.name, obs);
                @(posedge clk);
            end
        end
    endtask

    task automatic test_lw_waits();
        txn_t t;
        set_ir(32'h0002A303);
        sb.push_back(mk(1'b1, 1'b0, 1'b0, e_fetch(1'b1), "lw_fetch"));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, e_decode(1'b0), "lw_decode"));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, e_memadr(), "lw_memadr"));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, e_memread(), "lw_memread_w0"));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, e_memread(), "lw_memread_w1"));
        sb.push_back(mk(1'b1, 1'b0, 1'b0, e_memread(), "lw_memread_go"));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, e_memwb(), "lw_memwb"));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, e_fetch(1'b0), "lw_fetch_stall"));
        while (sb.size() > 0) begin
            t = sb.pop_front();
            #1; mem_ready_i = t.rdy; zero_i = t.zero; rst_i = t.rst;
            #3; total++;
            if (obs !== t.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", t.name, obs, t.exp);
            end else $display("ok   %s: %h", t.name, obs);
            @(posedge clk);
        end
    endtask

    task automatic test_sw_wait();
        txn_t t;
        set_ir(32'h0062A223);
        sb.push_back(mk(1'b1, 1'b0, 1'b0, e_fetch(1'b1), "sw_fetch"));
        sb.push_back(mk(1'b1, 1'b0, 1'b0, e_decode(1'b0), "sw_decode"));
        sb.push_back(mk(1'b1, 1'b0, 1'b0, e_memadr(), "sw_memadr"));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, e_memwrite(), "sw_memwrite_w0"));
        sb.push_back(mk(1'b1, 1'b0, 1'b0, e_memwrite(), "sw_memwrite_go"));
        while (sb.size() > 0) begin
            t = sb.pop_front();
            #1; mem_ready_i = t.rdy; zero_i = t.zero; rst_i = t.rst;
            #3; total++;
            if (obs !== t.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", t.name, obs, t.exp);
            end else $display("ok   %s: %h", t.name, obs);
            @(posedge clk);
        end
    endtask

    task automatic test_branch();
        logic [31:0] irs [3] = '{32'h00208463, 32'h00208463, 32'h00209463};
        logic        zs  [3] = '{1'b1, 1'b0, 1'b0};
        logic        pcw [3] = '{1'b1, 1'b0, 1'b1};
        txn_t t;
        for (int k = 0; k < 3; k++) begin
            set_ir(irs[k]);
            sb.push_back(mk(1'b1, zs[k], 1'b0, e_fetch(1'b1), $sformatf("br%0d_fetch", k)));
            sb.push_back(mk(1'b1, zs[k], 1'b0, e_decode(1'b0), $sformatf("br%0d_decode", k)));
            sb.push_back(mk(1'b1, zs[k], 1'b0, e_branch(pcw[k]), $sformatf("br%0d_branch", k)));
            while (sb.size() > 0) begin
                t = sb.pop_front();
                #1; mem_ready_i = t.rdy; zero_i = t.zero; rst_i = t.rst;
                #3; total++;
                if (obs !== t.exp) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", t.name, obs, t.exp);
                end else $display("ok   %s: %h", t.name, obs);
                @(posedge clk);
            end
        end
    endtask

    task automatic test_jal_illegal();
        txn_t t;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                set_ir(32'h008000EF);
                sb.push_back(mk(1'b1, 1'b0, 1'b0, e_fetch(1'b1), "jal_fetch"));
                sb.push_back(mk(1'b1, 1'b0, 1'b0, e_decode(1'b0), "jal_decode"));
                sb.push_back(mk(1'b1, 1'b0, 1'b0, e_jal(), "jal_jal"));
                sb.push_back(mk(1'b1, 1'b0, 1'b0, e_aluwb(), "jal_aluwb"));
            end else begin
                set_ir(32'h0000007F);
                sb.push_back(mk(1'b1, 1'b0, 1'b0, e_fetch(1'b1), "ill_fetch"));
                sb.push_back(mk(1'b1, 1'b0, 1'b0, e_decode(1'b1), "ill_decode"));
                sb.push_back(mk(1'b0, 1'b0, 1'b0, e_fetch(1'b0), "ill_back_fetch"));
            end
            while (sb.size() > 0) begin
                t = sb.pop_front();
                #1; mem_ready_i = t.rdy; zero_i = t.zero; rst_i = t.rst;
                #3; total++;
                if (obs !== t.exp) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", t.name, obs, t.exp);
                end else $display("ok   %s: %h", t.name, obs);
                @(posedge clk);
            end
        end
    endtask

    task automatic test_reset_midwrite();
        txn_t t;
        set_ir(32'h0062A223);
        sb.push_back(mk(1'b1, 1'b0, 1'b0, e_fetch(1'b1), "rstw_fetch"));
        sb.push_back(mk(1'b1, 1'b0, 1'b0, e_decode(1'b0), "rstw_decode"));
        sb.push_back(mk(1'b1, 1'b0, 1'b0, e_memadr(), "rstw_memadr"));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, e_memwrite(), "rstw_memwrite_w0"));
        sb.push_back(mk(1'b0, 1'b0, 1'b1, ev(4'd5, 7'b0010000, 2'b00, 2'b00, 2'b00, 3'b000),
                        "rstw_reset_cycle"));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, e_fetch(1'b0), "rstw_after_edge"));
        while (sb.size() > 0) begin
            t = sb.pop_front();
            #1; mem_ready_i = t.rdy; zero_i = t.zero; rst_i = t.rst;
            #3; total++;
            if (obs !== t.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", t.name, obs, t.exp);
            end else $display("ok   %s: %h", t.name, obs);
            @(posedge clk);
        end
    endtask

    task automatic test_immsrc();
        logic [6:0] ops  [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1100011, 7'b1101111, 7'b1111111, 7'b0110111};
        logic [1:0] imms [8] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00};
        #1; mem_ready_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            op_i = ops[k];
            #1; total++;
            if (immsrc_o !== imms[k]) begin
                bad++;
                $display("FAIL immsrc_op%07b: got %b want %b", ops[k], immsrc_o, imms[k]);
            end else $display("ok   immsrc_op%07b: %b", ops[k], immsrc_o);
        end
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu_ops();
        test_lw_waits();
        test_sw_wait();
        test_branch();
        test_jal_illegal();
        test_reset_midwrite();
        test_immsrc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
